cafe_order_panel: RTL and testbench

- Customer-facing front end for the coffee brewer.
- Counts coins into a credit and accepts a one-hot drink button when credit covers the price.
- Drives the brewer's one-hot cofeeSelection, then watches the brewer's 5-bit valve status to detect brew start and brew completion.
- Refunds remaining credit as change pulses.

---
 rtl/cafe_order_panel_if.sv | 37 +++
 rtl/cafe_order_panel.sv | 188 ++++++++++++++++++
 tb/tb_cafe_order_panel.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/cafe_order_panel_if.sv
// cafe_order_panel_if: bundles the customer-side and brewer-side signals of
// the cafe order panel.
//   master  - drives coin, button, cancel and status; observes the panel outputs
//   slave   - the panel itself
// Signals:
//   coin           one-cycle pulse, one coin unit
//   button[3:0]    one-hot drink request
//   cancel         refund request
//   status[4:0]    brewer valves {agua, cafe, leche, chocolate, azucar}
//   cofeeSelection one-hot drink command to the brewer
//   credit         current credit
//   change_pulse   one pulse per refunded unit
//   busy           drink in progress
//   error          sticky fault flag
interface cafe_order_panel_if #(
    parameter int unsigned CREDIT_W = 4
);
    logic                coin;
    logic [3:0]          button;
    logic                cancel;
    logic [4:0]          status;
    logic [3:0]          cofeeSelection;
    logic [CREDIT_W-1:0] credit;
    logic                change_pulse;
    logic                busy;
    logic                error;

    modport master (
        output coin, button, cancel, status,
        input  cofeeSelection, credit, change_pulse, busy, error
    );

    modport slave (
        input  coin, button, cancel, status,
        output cofeeSelection, credit, change_pulse, busy, error
    );
endinterface

// File: rtl/cafe_order_panel.sv
// cafe_order_panel: customer front end for the coffee brewer. Counts coins into
// a credit, accepts a one-hot drink button once credit covers its price, drives
// the brewer's one-hot selection, follows the valve status through brew start
// and completion, and refunds remaining credit as change pulses.
// Ports:
//   Clock  - single clock, posedge
//   Reset  - synchronous, active-high
//   bus    - cafe_order_panel_if.slave (coin/button/cancel/status in;
//            cofeeSelection/credit/change_pulse/busy/error out, all registered)
// Optional feature: define BREW_WATCHDOG_EN to abort a brew whose status stays
// non-zero for BREW_TIMEOUT cycles (error set, no price refund).
module cafe_order_panel #(
    parameter int unsigned PRICE_EXP     = 2,
    parameter int unsigned PRICE_LECHE   = 3,
    parameter int unsigned PRICE_CAP     = 3,
    parameter int unsigned PRICE_MOCCA   = 4,
    parameter int unsigned CREDIT_W      = 4,
    parameter int unsigned START_TIMEOUT = 16,
    parameter int unsigned BREW_TIMEOUT  = 255
) (
    input  logic               Clock,
    input  logic               Reset,
    cafe_order_panel_if.slave  bus
);
    // One counter serves both the start timeout and the brew watchdog.
    localparam int unsigned CNT_MAX = (BREW_TIMEOUT > START_TIMEOUT) ? BREW_TIMEOUT
                                                                    : START_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]    START_LAST = CNT_W'(START_TIMEOUT - 1);
`ifdef BREW_WATCHDOG_EN
    localparam logic [CNT_W-1:0]    BREW_LAST  = CNT_W'(BREW_TIMEOUT - 1);
`endif
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;
    localparam logic [CREDIT_W-1:0] P_EXP      = CREDIT_W'(PRICE_EXP);
    localparam logic [CREDIT_W-1:0] P_LECHE    = CREDIT_W'(PRICE_LECHE);
    localparam logic [CREDIT_W-1:0] P_CAP      = CREDIT_W'(PRICE_CAP);
    localparam logic [CREDIT_W-1:0] P_MOCCA    = CREDIT_W'(PRICE_MOCCA);

    typedef enum logic [2:0] {
        StIdle,
        StCredit,
        StIssue,
        StWaitStart,
        StBrewing,
        StChange
    } state_e;

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] price_q, price_d;
    logic [3:0]          sel_q, sel_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pulse_q, pulse_d;
    logic                busy_q, busy_d;
    logic                error_q, error_d;

    logic                btn_ok;
    logic [CREDIT_W-1:0] btn_price;
    logic                coin_ok;
    logic [CREDIT_W-1:0] coin_inc;

    // Button decode: only a single set bit is a legal request.
    always_comb begin
        btn_ok    = 1'b0;
        btn_price = '0;
        case (bus.button)
            4'b0001: begin btn_ok = 1'b1; btn_price = P_EXP;   end
            4'b0010: begin btn_ok = 1'b1; btn_price = P_LECHE; end
            4'b0100: begin btn_ok = 1'b1; btn_price = P_CAP;   end
            4'b1000: begin btn_ok = 1'b1; btn_price = P_MOCCA; end
            default: ;
        endcase
    end

    assign coin_ok  = bus.coin && (state_q == StIdle || state_q == StCredit) &&
                      (credit_q != CREDIT_MAX);
    assign coin_inc = {{(CREDIT_W-1){1'b0}}, coin_ok};

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        price_d  = price_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        pulse_d  = 1'b0;
        busy_d   = busy_q;
        error_d  = error_q;

        if (coin_ok) begin
            credit_d = credit_q + coin_inc;
            error_d  = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (coin_ok) state_d = StCredit;
            end
            StCredit: begin
                if (bus.cancel) begin
                    state_d = StChange;
                end else if (btn_ok && credit_q >= btn_price) begin
                    // Decision uses registered credit; a same-cycle coin still counts.
                    state_d  = StIssue;
                    sel_d    = bus.button;
                    price_d  = btn_price;
                    credit_d = credit_q + coin_inc - btn_price;
                    busy_d   = 1'b1;
                end
            end
            StIssue: begin
                state_d = StWaitStart;
                cnt_d   = '0;
            end
            StWaitStart: begin
                if (bus.status != 5'd0) begin
                    state_d = StBrewing;
                    cnt_d   = '0;
                end else if (cnt_q == START_LAST) begin
                    // Brewer never started: refund the drink and pay out.
                    state_d  = StChange;
                    error_d  = 1'b1;
                    credit_d = credit_q + price_q;
                    sel_d    = '0;
                    busy_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBrewing: begin
                if (bus.status == 5'd0) begin
                    state_d = StChange;
                    sel_d   = '0;
                    busy_d  = 1'b0;
`ifdef BREW_WATCHDOG_EN
                end else if (cnt_q == BREW_LAST) begin
                    state_d = StChange;
                    error_d = 1'b1;
                    sel_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            StChange: begin
                if (credit_q == '0) begin
                    state_d = StIdle;
                end else if (!pulse_q) begin
                    // High one cycle, low the next, one unit per high cycle.
                    pulse_d  = 1'b1;
                    credit_d = credit_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= StIdle;
            credit_q <= '0;
            price_q  <= '0;
            sel_q    <= '0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
            busy_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            price_q  <= price_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
            busy_q   <= busy_d;
            error_q  <= error_d;
        end
    end

    assign bus.cofeeSelection = sel_q;
    assign bus.credit         = credit_q;
    assign bus.change_pulse   = pulse_q;
    assign bus.busy           = busy_q;
    assign bus.error          = error_q;
endmodule

// File: tb/tb_cafe_order_panel.sv
// Directed bench for cafe_order_panel; inputs change 1 time unit after the
// rising edge and outputs are sampled at that same point.
module tb_cafe_order_panel;
    logic Clock;
    logic Reset;
    int   n_pass;
    int   n_total;
    int   pulses;
    int   adj;

    cafe_order_panel_if #(.CREDIT_W(4)) bus ();

    cafe_order_panel #(
        .PRICE_EXP     (2),
        .PRICE_LECHE   (3),
        .PRICE_CAP     (3),
        .PRICE_MOCCA   (4),
        .CREDIT_W      (4),
        .START_TIMEOUT (16),
        .BREW_TIMEOUT  (8)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic coins(input int n);
        for (int i = 0; i < n; i++) begin
            bus.coin = 1'b1;
            step();
        end
        bus.coin = 1'b0;
    endtask

    // Counts change pulses over a fixed window and flags back-to-back pulses.
    task automatic drain(input int cycles, output int np, output int nadj);
        logic prev;
        prev = 1'b0;
        np   = 0;
        nadj = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (bus.change_pulse) begin
                np++;
                if (prev) nadj++;
            end
            prev = bus.change_pulse;
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        Reset   = 1'b1;
        bus.coin   = 1'b0;
        bus.button = 4'b0000;
        bus.cancel = 1'b0;
        bus.status = 5'b00000;
        step();
        step();
        chk("rst_credit", 32'(bus.credit), 32'd0);
        chk("rst_sel",    32'(bus.cofeeSelection), 32'd0);
        chk("rst_pulse",  32'(bus.change_pulse), 32'd0);
        chk("rst_busy",   32'(bus.busy), 32'd0);
        chk("rst_error",  32'(bus.error), 32'd0);
        Reset = 1'b0;

        // Espresso with 3 coins, one unit back
        coins(3);
        chk("t1_credit3", 32'(bus.credit), 32'd3);
        bus.button = 4'b0001;
        step();
        bus.button = 4'b0000;
        chk("t1_issue_sel",    32'(bus.cofeeSelection), 32'h1);
        chk("t1_issue_credit", 32'(bus.credit), 32'd1);
        chk("t1_issue_busy",   32'(bus.busy), 32'd1);
        step();
        bus.status = 5'b10000;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t1_brew_sel", 32'(bus.cofeeSelection), 32'h1);
        end
        bus.status = 5'b00000;
        step();
        chk("t1_done_sel",  32'(bus.cofeeSelection), 32'h0);
        chk("t1_done_busy", 32'(bus.busy), 32'd0);
        drain(6, pulses, adj);
        chk("t1_pulses", 32'(pulses), 32'd1);
        chk("t1_credit0", 32'(bus.credit), 32'd0);

        // Mocca with too little credit, then cancel
        coins(2);
        bus.button = 4'b1000;
        step();
        bus.button = 4'b0000;
        chk("t2_credit", 32'(bus.credit), 32'd2);
        chk("t2_sel",    32'(bus.cofeeSelection), 32'h0);
        chk("t2_busy",   32'(bus.busy), 32'd0);
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
        drain(8, pulses, adj);
        chk("t2_pulses", 32'(pulses), 32'd2);
        chk("t2_adj",    32'(adj), 32'd0);
        chk("t2_credit0", 32'(bus.credit), 32'd0);

        // Two-bit button ignored; cappuccino never starts -> timeout refund
        coins(4);
        bus.button = 4'b0110;
        step();
        chk("t3_multi_credit", 32'(bus.credit), 32'd4);
        chk("t3_multi_sel",    32'(bus.cofeeSelection), 32'h0);
        bus.button = 4'b0100;
        step();
        bus.button = 4'b0000;
        chk("t3_issue_sel",    32'(bus.cofeeSelection), 32'h4);
        chk("t3_issue_credit", 32'(bus.credit), 32'd1);
        for (int i = 0; i < 16; i++) step();
        chk("t3_wait_sel",   32'(bus.cofeeSelection), 32'h4);
        chk("t3_wait_error", 32'(bus.error), 32'd0);
        step();
        chk("t3_to_error",  32'(bus.error), 32'd1);
        chk("t3_to_credit", 32'(bus.credit), 32'd4);
        chk("t3_to_sel",    32'(bus.cofeeSelection), 32'h0);
        chk("t3_to_busy",   32'(bus.busy), 32'd0);
        drain(12, pulses, adj);
        chk("t3_pulses", 32'(pulses), 32'd4);
        chk("t3_adj",    32'(adj), 32'd0);
        chk("t3_error_sticky", 32'(bus.error), 32'd1);
        coins(1);
        chk("t3_error_clr",  32'(bus.error), 32'd0);
        chk("t3_coin_credit", 32'(bus.credit), 32'd1);
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
        drain(4, pulses, adj);
        chk("t3_cancel_pulses", 32'(pulses), 32'd1);

        // Saturation at 15
        coins(15);
        chk("t4_credit15", 32'(bus.credit), 32'd15);
        coins(1);
        chk("t4_sat_credit", 32'(bus.credit), 32'd15);
        chk("t4_sat_pulse",  32'(bus.change_pulse), 32'd0);
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
        drain(34, pulses, adj);
        chk("t4_pulses", 32'(pulses), 32'd15);
        chk("t4_adj",    32'(adj), 32'd0);

        // Coin and cancel together
        coins(2);
        bus.coin   = 1'b1;
        bus.cancel = 1'b1;
        step();
        bus.coin   = 1'b0;
        bus.cancel = 1'b0;
        chk("t5_credit3", 32'(bus.credit), 32'd3);
        drain(10, pulses, adj);
        chk("t5_pulses", 32'(pulses), 32'd3);

        // Status stuck non-zero during brewing
        coins(2);
        bus.button = 4'b0001;
        step();
        bus.button = 4'b0000;
        chk("t6_issue_credit", 32'(bus.credit), 32'd0);
        bus.status = 5'b01000;
        step();
        step();
        for (int i = 0; i < 7; i++) begin
            step();
            chk("t6_brew_sel", 32'(bus.cofeeSelection), 32'h1);
        end
        step();
`ifdef BREW_WATCHDOG_EN
        chk("t6_wd_error",  32'(bus.error), 32'd1);
        chk("t6_wd_sel",    32'(bus.cofeeSelection), 32'h0);
        chk("t6_wd_credit", 32'(bus.credit), 32'd0);
        chk("t6_wd_busy",   32'(bus.busy), 32'd0);
        step();
        bus.status = 5'b00000;
`else
        chk("t6_nowd_sel",   32'(bus.cofeeSelection), 32'h1);
        chk("t6_nowd_busy",  32'(bus.busy), 32'd1);
        chk("t6_nowd_error", 32'(bus.error), 32'd0);
        bus.status = 5'b00000;
        step();
        chk("t6_end_sel", 32'(bus.cofeeSelection), 32'h0);
        step();
`endif
        chk("t6_idle_busy",   32'(bus.busy), 32'd0);
        chk("t6_idle_credit", 32'(bus.credit), 32'd0);

        // Reset while waiting for brew start
        coins(3);
        bus.button = 4'b0001;
        step();
        bus.button = 4'b0000;
        step();
        chk("t7_wait_busy", 32'(bus.busy), 32'd1);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("t7_rst_credit", 32'(bus.credit), 32'd0);
        chk("t7_rst_sel",    32'(bus.cofeeSelection), 32'h0);
        chk("t7_rst_busy",   32'(bus.busy), 32'd0);
        chk("t7_rst_pulse",  32'(bus.change_pulse), 32'd0);
        chk("t7_rst_error",  32'(bus.error), 32'd0);
        drain(4, pulses, adj);
        chk("t7_no_pulses", 32'(pulses), 32'd0);
        coins(1);
        chk("t7_after_coin", 32'(bus.credit), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
